// File: rtl/dm_ctrl_pkg.sv
// dm_ctrl_pkg: shared definitions for the data-memory controller.
//   - state_t   : controller FSM encoding (also exported on the debug port)
//   - BE_WORD / BE_NONE : byte-enable patterns that skip read-modify-write
//   - merge_lanes : per-byte select between new store data and the old word
package dm_ctrl_pkg;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WBACK = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // Lane i of the result comes from new_w when be[i] is set, else from old_w.
  function automatic logic [31:0] merge_lanes(input logic [3:0]  be,
                                              input logic [31:0] new_w,
                                              input logic [31:0] old_w);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_ctrl_if.sv
// dm_ctrl_if: bundles the two requester ports and the data-memory port.
//   Requester side : req/we/be/addr/wdata (x2) in, ready0/ready1/rdata/busy out
//   Memory side    : mem_addr/mem_we/mem_wdata out, mem_rdata in
//   Debug          : dbg_state exposes the controller FSM state
//
// Handshake: a requester raises reqN with we/be/addr/wdata stable and keeps
// them so until it sees readyN=1 for one cycle; it lowers reqN on that clock
// edge. reqN still high in the following idle cycle is a new request. rdata is
// meaningful while the matching ready is high and holds until the next load
// completes. mem_rdata answers the mem_addr of the previous cycle.
interface dm_ctrl_if #(parameter int MEM_AW = 10);
  logic                 req0, req1;
  logic                 we0, we1;
  logic [3:0]           be0, be1;
  logic [31:0]          addr0, addr1;
  logic [31:0]          wdata0, wdata1;
  logic                 ready0, ready1;
  logic [31:0]          rdata;
  logic                 busy;
  logic [MEM_AW-1:0]    mem_addr;
  logic                 mem_we;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;
  dm_ctrl_pkg::state_t  dbg_state;

  modport slave (
    input  req0, req1, we0, we1, be0, be1, addr0, addr1, wdata0, wdata1,
    input  mem_rdata,
    output ready0, ready1, rdata, busy, mem_addr, mem_we, mem_wdata, dbg_state
  );

  modport master (
    output req0, req1, we0, we1, be0, be1, addr0, addr1, wdata0, wdata1,
    output mem_rdata,
    input  ready0, ready1, rdata, busy, mem_addr, mem_we, mem_wdata, dbg_state
  );
endinterface

// File: rtl/dm_ctrl_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : requests
//   advance    : pulse after a grant has been served; next tie goes to the
//                other port
//   grant[1:0] : one-hot grant (combinational from req and the pointer)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // ptr = index of the port preferred on a tie; reset prefers port 0.
  logic ptr_q, ptr_d;

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && (grant != 2'b00)) ptr_d = grant[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dm_ctrl.sv
// dm_ctrl: sequences a single-port word memory shared by two requesters
// (port 0 = CPU MEM stage, port 1 = debug/DMA loader).
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : dm_ctrl_if.slave -- requester handshakes, memory port, debug state
// Loads and partial stores read the word first (memory read data arrives one
// cycle after the address); partial stores then write back the merged word.
module dm_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int MEM_AW = 10,
  parameter int DW     = 32
) (
  input  logic        clk,
  input  logic        reset,
  dm_ctrl_if.slave    bus
);

  state_t            state_q, state_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [MEM_AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     merged_q, merged_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;

  logic [1:0]        arb_req, grant;
  logic              advance;
  logic              mem_we_c, ready0_c, ready1_c;
  logic [DW-1:0]     mem_wdata_c;
  logic [MEM_AW-1:0] mem_addr_c;

  // Outside IDLE the arbiter only sees the port being served, so the grant
  // it reports during RESP is that port and the pointer moves past it.
  assign arb_req = (state_q == S_IDLE) ? {bus.req1, bus.req0}
                                       : (port_q ? 2'b10 : 2'b01);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (reset),
    .req     (arb_req),
    .advance (advance),
    .grant   (grant)
  );

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    we_d        = we_q;
    be_d        = be_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    merged_d    = merged_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_we_c    = 1'b0;
    mem_wdata_c = '0;
    mem_addr_c  = mem_addr_q;
    ready0_c    = 1'b0;
    ready1_c    = 1'b0;
    advance     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant != 2'b00) begin
          port_d  = grant[1];
          we_d    = grant[1] ? bus.we1    : bus.we0;
          be_d    = grant[1] ? bus.be1    : bus.be0;
          waddr_d = grant[1] ? bus.addr1[MEM_AW+1:2] : bus.addr0[MEM_AW+1:2];
          wdata_d = grant[1] ? bus.wdata1 : bus.wdata0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_addr_c = waddr_q;
        mem_addr_d = waddr_q;
        if (we_q && (be_q == BE_WORD)) begin
          mem_we_c    = 1'b1;
          mem_wdata_c = wdata_q;
          state_d     = S_RESP;
        end else if (we_q && (be_q == BE_NONE)) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (we_q) begin
          merged_d = merge_lanes(be_q, wdata_q, bus.mem_rdata);
          state_d  = S_WBACK;
        end else begin
          rdata_d = bus.mem_rdata;
          state_d = S_RESP;
        end
      end
      S_WBACK: begin
        mem_we_c    = 1'b1;
        mem_wdata_c = merged_q;
        state_d     = S_RESP;
      end
      S_RESP: begin
        ready0_c = ~port_q;
        ready1_c = port_q;
        advance  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      merged_q   <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      we_q       <= we_d;
      be_q       <= be_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      merged_q   <= merged_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign bus.ready0    = ready0_c;
  assign bus.ready1    = ready1_c;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.dbg_state = state_q;

  // Address bits outside the word index are don't-care by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr0[31:MEM_AW+2], bus.addr0[1:0],
                              bus.addr1[31:MEM_AW+2], bus.addr1[1:0]};

endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: self-checking bench for dm_ctrl with a registered-read memory
// model, a directed vector table, hand-written arbitration/reset sequences
// and randomized single-port traffic against a transaction-level model.
module tb_dm_ctrl;
  import dm_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_ctrl_if #(.MEM_AW(10)) bus ();

  dm_ctrl #(.MEM_AW(10), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- memory model (registered read) ----------------
  logic [31:0] mem [1024] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  // ---------------- bus monitor ----------------
  int          we_cnt = 0, b2b_cnt = 0, both_rdy_cnt = 0, rdy_cnt = 0, drift_cnt = 0;
  logic        prev_we = 1'b0;
  logic [9:0]  last_we_addr = '0;
  logic [9:0]  hold_addr = '0;
  always @(negedge clk) begin
    prev_we <= bus.mem_we;
    if (bus.mem_we) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= bus.mem_addr;
    end
    if (bus.mem_we && prev_we) b2b_cnt <= b2b_cnt + 1;
    if (bus.ready0 && bus.ready1) both_rdy_cnt <= both_rdy_cnt + 1;
    if (bus.ready0 || bus.ready1) rdy_cnt <= rdy_cnt + 1;
    if (bus.dbg_state == S_ISSUE) hold_addr <= bus.mem_addr;
    if ((bus.dbg_state == S_WAIT || bus.dbg_state == S_WBACK) &&
        bus.mem_addr != hold_addr) drift_cnt <= drift_cnt + 1;
  end

  // ---------------- scoreboard / reference model ----------------
  int          n_pass = 0, n_total = 0;
  logic [31:0] ref_mem [1024];
  logic [31:0] ref_last;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, want);
  endtask

  // Transaction-level rules: word = addr/4 mod 1024; stores replace enabled
  // bytes; latency 2 for full/empty stores, 3 for loads, 4 for partial stores.
  task automatic model_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] e_rd,
                           output int e_lat, output int e_wr, output int e_word);
    e_word = int'((addr >> 2) % 32'd1024);
    if (!we) begin
      ref_last = ref_mem[e_word];
      e_lat = 3;
      e_wr  = 0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[e_word][8*i +: 8] = wdata[8*i +: 8];
      e_wr  = (be != 4'h0) ? 1 : 0;
      e_lat = (be == 4'hF || be == 4'h0) ? 2 : 4;
    end
    e_rd = ref_last;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    ref_last = '0;
  endtask

  task automatic do_txn(input logic port, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output int lat, output int writes,
                        output logic [9:0] waddr);
    int start;
    @(posedge clk);
    #1;
    start = we_cnt;
    if (!port) begin
      bus.we0 = we; bus.be0 = be; bus.addr0 = addr; bus.wdata0 = wdata; bus.req0 = 1'b1;
    end else begin
      bus.we1 = we; bus.be1 = be; bus.addr1 = addr; bus.wdata1 = wdata; bus.req1 = 1'b1;
    end
    lat = -1;
    rd  = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if ((!port && bus.ready0) || (port && bus.ready1)) begin
        lat = c;
        rd  = bus.rdata;
        break;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    writes = we_cnt - start;
    waddr  = last_we_addr;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        port;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    int          writes;
    int          word;
    logic [31:0] word_val;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] rd, e_rd;
    int          lat, wr, e_lat, e_wr, e_word;
    logic [9:0]  waddr;
    int          got[4];
    int          n_got, cyc;

    reset = 1'b0;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.be0 = '0; bus.be1 = '0; bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    ref_last = '0;

    // ---- reset state ----
    @(posedge clk);
    #1;
    chk("rst_ready0", 32'(bus.ready0), 32'h0);
    chk("rst_ready1", 32'(bus.ready1), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_busy", 32'(bus.busy), 32'h0);

    // ---- table: port, we, be, addr, wdata, lat, rdata, writes, word, word_val ----
    vecs[0]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0020, 32'h1234_5678, 2, 32'h0000_0000, 1, 8,    32'h1234_5678};
    vecs[1]  = '{1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 2, 32'h0000_0000, 1, 4,    32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 1'b1, 4'h2, 32'h0000_0011, 32'h0000_5500, 4, 32'h0000_0000, 1, 4,    32'hDEAD_55EF};
    vecs[3]  = '{1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000, 3, 32'hDEAD_55EF, 0, 4,    32'hDEAD_55EF};
    vecs[4]  = '{1'b0, 1'b1, 4'h0, 32'h0000_0020, 32'hFFFF_FFFF, 2, 32'hDEAD_55EF, 0, 8,    32'h1234_5678};
    vecs[5]  = '{1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0000_0000, 3, 32'h1234_5678, 0, 8,    32'h1234_5678};
    vecs[6]  = '{1'b1, 1'b1, 4'h9, 32'h0000_1010, 32'hAABB_CCDD, 4, 32'h1234_5678, 1, 4,    32'hAAAD_55DD};
    vecs[7]  = '{1'b0, 1'b0, 4'hF, 32'hFFFF_F013, 32'h0000_0000, 3, 32'hAAAD_55DD, 0, 4,    32'hAAAD_55DD};
    vecs[8]  = '{1'b0, 1'b1, 4'hC, 32'h0000_07FC, 32'h1122_3344, 4, 32'hAAAD_55DD, 1, 511,  32'h1122_0000};
    vecs[9]  = '{1'b1, 1'b1, 4'hF, 32'h0000_0FFC, 32'hCAFE_F00D, 2, 32'hAAAD_55DD, 1, 1023, 32'hCAFE_F00D};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 32'h0000_0FFE, 32'h0000_0000, 3, 32'hCAFE_F00D, 0, 1023, 32'hCAFE_F00D};
    vecs[11] = '{1'b1, 1'b0, 4'hF, 32'h0000_1004, 32'h0000_0000, 3, 32'h0000_0000, 0, 1,    32'h0000_0000};
    vecs[12] = '{1'b0, 1'b1, 4'h6, 32'h0000_07FE, 32'h00AB_CD00, 4, 32'h0000_0000, 1, 511,  32'h11AB_CD00};

    for (int v = 0; v < 13; v++) begin
      do_txn(vecs[v].port, vecs[v].we, vecs[v].be, vecs[v].addr, vecs[v].wdata, rd, lat, wr, waddr);
      model_txn(vecs[v].we, vecs[v].be, vecs[v].addr, vecs[v].wdata, e_rd, e_lat, e_wr, e_word);
      chk($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].lat));
      chk($sformatf("vec%0d_rdata", v), rd, vecs[v].rdata);
      chk($sformatf("vec%0d_writes", v), 32'(wr), 32'(vecs[v].writes));
      chk($sformatf("vec%0d_word", v), mem[vecs[v].word], vecs[v].word_val);
      if (vecs[v].writes == 1) chk($sformatf("vec%0d_waddr", v), 32'(waddr), 32'(vecs[v].word));
    end

    // ---- both ports requesting continuously: grants alternate from port 0 ----
    do_reset();
    @(posedge clk);
    #1;
    bus.we0 = 1'b1; bus.be0 = 4'hF; bus.addr0 = 32'h50; bus.wdata0 = 32'hA0A0_0001;
    bus.we1 = 1'b1; bus.be1 = 4'hF; bus.addr1 = 32'h54; bus.wdata1 = 32'hB1B1_0002;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    n_got = 0;
    cyc   = 0;
    while (n_got < 4 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.ready0) begin
        got[n_got] = 0; n_got++;
        model_txn(1'b1, 4'hF, 32'h50, 32'hA0A0_0001, e_rd, e_lat, e_wr, e_word);
      end else if (bus.ready1) begin
        got[n_got] = 1; n_got++;
        model_txn(1'b1, 4'hF, 32'h54, 32'hB1B1_0002, e_rd, e_lat, e_wr, e_word);
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("rr_count", 32'(n_got), 32'd4);
    for (int i = 0; i < n_got; i++) chk($sformatf("rr_grant%0d", i), 32'(got[i]), 32'(i % 2));
    chk("rr_word20", mem[20], ref_mem[20]);
    chk("rr_word21", mem[21], ref_mem[21]);

    // ---- reset during WAIT of a partial store ----
    do_txn(1'b0, 1'b0, 4'hF, 32'h10, 32'h0, rd, lat, wr, waddr);
    model_txn(1'b0, 4'hF, 32'h10, 32'h0, e_rd, e_lat, e_wr, e_word);
    chk("pre_load_rdata", rd, e_rd);
    @(posedge clk);
    #1;
    bus.we1 = 1'b1; bus.be1 = 4'b0100; bus.addr1 = 32'h44; bus.wdata1 = 32'h0077_0000;
    bus.req1 = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("mid_state", 32'(bus.dbg_state), 32'(S_WAIT));
    chk("mid_busy", 32'(bus.busy), 32'h1);
    begin
      int we0_snap, rdy_snap;
      we0_snap = we_cnt;
      rdy_snap = rdy_cnt;
      #1 reset = 1'b0;
      #1;
      bus.req1 = 1'b0;
      chk("ar_state", 32'(bus.dbg_state), 32'(S_IDLE));
      chk("ar_busy", 32'(bus.busy), 32'h0);
      chk("ar_rdata", bus.rdata, 32'h0);
      chk("ar_mem_addr", 32'(bus.mem_addr), 32'h0);
      chk("ar_mem_we", 32'(bus.mem_we), 32'h0);
      chk("ar_mem_wdata", bus.mem_wdata, 32'h0);
      chk("ar_ready", 32'({bus.ready1, bus.ready0}), 32'h0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      ref_last = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("ar_no_write", 32'(we_cnt - we0_snap), 32'h0);
      chk("ar_no_ready", 32'(rdy_cnt - rdy_snap), 32'h0);
      chk("ar_word17", mem[17], ref_mem[17]);
    end
    do_txn(1'b1, 1'b1, 4'b0100, 32'h44, 32'h0077_0000, rd, lat, wr, waddr);
    model_txn(1'b1, 4'b0100, 32'h44, 32'h0077_0000, e_rd, e_lat, e_wr, e_word);
    chk("reissue_lat", 32'(lat), 32'(e_lat));
    chk("reissue_word17", mem[17], ref_mem[17]);
    chk("reissue_rdata", rd, e_rd);

    // ---- randomized single-port traffic ----
    for (int t = 0; t < 40; t++) begin
      logic        p, we;
      logic [3:0]  be;
      logic [31:0] addr, wdata;
      p     = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      be    = 4'($urandom_range(0, 15));
      addr  = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(32, 47)) << 2);
      wdata = $urandom;
      do_txn(p, we, be, addr, wdata, rd, lat, wr, waddr);
      model_txn(we, be, addr, wdata, e_rd, e_lat, e_wr, e_word);
      exp_q.push_back(e_rd);
      chk($sformatf("rnd%0d_lat", t), 32'(lat), 32'(e_lat));
      chk($sformatf("rnd%0d_rdata", t), rd, exp_q.pop_front());
      chk($sformatf("rnd%0d_writes", t), 32'(wr), 32'(e_wr));
      chk($sformatf("rnd%0d_word", t), mem[e_word], ref_mem[e_word]);
      if (e_wr == 1) chk($sformatf("rnd%0d_waddr", t), 32'(waddr), 32'(e_word));
    end

    // ---- bus rules collected over the whole run ----
    @(posedge clk);
    #1;
    chk("no_b2b_we", 32'(b2b_cnt), 32'h0);
    chk("no_dual_ready", 32'(both_rdy_cnt), 32'h0);
    chk("addr_stable", 32'(drift_cnt), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
